// File: rtl/iq_demod_integrator.sv
// ---------------------------------------------------------------------------
// iq_demod_integrator
//
// Purpose:
//    Demodulates a real ADC stream at fs/4 into I and Q. The results are
//    integrated over a window that a trigger opens. An optional delay can be
//    placed between the trigger and the start of the window. Each finished
//    measurement emits one signed (i_val, q_val) pair with a single-cycle
//    data_out strobe. That strobe feeds the 2D histogram stage directly.
//
// Ports:
//    clk100        in   1      system clock, rising edge
//    rst_n         in   1      asynchronous active-low reset
//    trigger       in   1      start-of-measurement pulse (honoured in IDLE only)
//    adc_valid     in   1      qualifies adc_data
//    adc_data      in   ADC_W  signed ADC sample
//    delay_cycles  in   16     clk100 cycles to wait after trigger
//    integ_len     in   16     number of valid samples to integrate
//    i_val         out  ACC_W  signed integrated I result
//    q_val         out  ACC_W  signed integrated Q result
//    data_out      out  1      one-cycle strobe, i_val/q_val newly valid
//    busy          out  1      high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module iq_demod_integrator #(
   parameter int ADC_W = 14,
   parameter int ACC_W = 32
) (
   input  logic                    clk100,
   input  logic                    rst_n,
   input  logic                    trigger,
   input  logic                    adc_valid,
   input  logic signed [ADC_W-1:0] adc_data,
   input  logic [15:0]             delay_cycles,
   input  logic [15:0]             integ_len,
   output logic signed [ACC_W-1:0] i_val,
   output logic signed [ACC_W-1:0] q_val,
   output logic                    data_out,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DELAY     = 2'd1,
      INTEGRATE = 2'd2,
      OUTPUT    = 2'd3
   } state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc_i;
   logic signed [ACC_W-1:0] acc_q;
   logic [15:0]             delay_cnt;
   logic [15:0]             remain;
   logic [1:0]              phase;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] next_i;
   logic signed [ACC_W-1:0] next_q;

   // The sample is sign-extended to full accumulator width before any
   // negation. Negating the most negative ADC code therefore cannot wrap.
   assign x_ext = {{(ACC_W-ADC_W){adc_data[ADC_W-1]}}, adc_data};

   // busy comes straight from the state register, so it cannot glitch.
   assign busy = (state != IDLE);

   // This is the fs/4 demodulation rule, applied to the current phase.
   // The four phases multiply the sample by cos = 1, 0, -1, 0 for I and by
   // sin = 0, 1, 0, -1 for Q. The result is the candidate value of the
   // accumulators, used once the sample is accepted.
   always_comb begin
      next_i = acc_i;
      next_q = acc_q;
      case (phase)
         2'd0:    next_i = acc_i + x_ext;
         2'd1:    next_q = acc_q + x_ext;
         2'd2:    next_i = acc_i - x_ext;
         default: next_q = acc_q - x_ext;
      endcase
   end

   // This is the measurement sequencer.
   // delay_cnt and remain hold the values latched at trigger time, so later
   // changes on the inputs do not disturb a running measurement.
   // When the last sample is accepted, the outputs are loaded and data_out
   // is raised in the same edge. They are visible during the OUTPUT cycle,
   // one cycle after the accepting edge.
   // A trigger that arrives outside IDLE is simply never looked at.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_i     <= '0;
         acc_q     <= '0;
         delay_cnt <= '0;
         remain    <= '0;
         phase     <= '0;
         i_val     <= '0;
         q_val     <= '0;
         data_out  <= 1'b0;
      end else begin
         data_out <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger && (integ_len != 16'd0)) begin
                  delay_cnt <= delay_cycles;
                  remain    <= integ_len;
                  acc_i     <= '0;
                  acc_q     <= '0;
                  phase     <= 2'd0;
                  state     <= (delay_cycles != 16'd0) ? DELAY : INTEGRATE;
               end
            end
            DELAY: begin
               delay_cnt <= delay_cnt - 16'd1;
               if (delay_cnt == 16'd1) begin
                  state <= INTEGRATE;
               end
            end
            INTEGRATE: begin
               if (adc_valid) begin
                  acc_i  <= next_i;
                  acc_q  <= next_q;
                  phase  <= phase + 2'd1;
                  remain <= remain - 16'd1;
                  if (remain == 16'd1) begin
                     i_val    <= next_i;
                     q_val    <= next_q;
                     data_out <= 1'b1;
                     state    <= OUTPUT;
                  end
               end
            end
            OUTPUT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iq_demod_integrator.sv
// ---------------------------------------------------------------------------
// tb_iq_demod_integrator
//
// Purpose:
//    Self-checking bench for iq_demod_integrator.
//    Directed steps run in a single initial block. Expected (I, Q) pairs are
//    computed from the samples that should be integrated, then queued.
//    A strobe monitor pops the queue and compares it with the DUT outputs.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_iq_demod_integrator;

   localparam int ADC_W = 14;
   localparam int ACC_W = 32;

   logic                    clk100;
   logic                    rst_n;
   logic                    trigger;
   logic                    adc_valid;
   logic signed [ADC_W-1:0] adc_data;
   logic [15:0]             delay_cycles;
   logic [15:0]             integ_len;
   logic signed [ACC_W-1:0] i_val;
   logic signed [ACC_W-1:0] q_val;
   logic                    data_out;
   logic                    busy;

   typedef struct {
      logic signed [ACC_W-1:0] i;
      logic signed [ACC_W-1:0] q;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   strobes  = 0;

   iq_demod_integrator #(
      .ADC_W(ADC_W),
      .ACC_W(ACC_W)
   ) dut (
      .clk100      (clk100),
      .rst_n       (rst_n),
      .trigger     (trigger),
      .adc_valid   (adc_valid),
      .adc_data    (adc_data),
      .delay_cycles(delay_cycles),
      .integ_len   (integ_len),
      .i_val       (i_val),
      .q_val       (q_val),
      .data_out    (data_out),
      .busy        (busy)
   );

   // 100 MHz clock.
   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   // Reference model of the fs/4 demodulator. The list holds the samples
   // that should be integrated, in order. Phase k mod 4 selects +I, +Q, -I, -Q.
   function automatic exp_t demod(input int s[$]);
      exp_t r;
      r.i = '0;
      r.q = '0;
      for (int k = 0; k < s.size(); k++) begin
         case (k % 4)
            0:       r.i = r.i + s[k];
            1:       r.q = r.q + s[k];
            2:       r.i = r.i - s[k];
            default: r.q = r.q - s[k];
         endcase
      end
      return r;
   endfunction

   task automatic check_output(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one ADC cycle. It returns 1 ns after the edge that consumed it.
   task automatic apply_stimulus(input logic v, input int d);
      adc_valid = v;
      adc_data  = d[ADC_W-1:0];
      @(posedge clk100);
      #1;
   endtask

   task automatic start_measure(input int dly, input int len);
      trigger      = 1'b1;
      delay_cycles = dly[15:0];
      integ_len    = len[15:0];
      adc_valid    = 1'b0;
      adc_data     = '0;
      @(posedge clk100);
      #1;
      trigger = 1'b0;
   endtask

   // Strobe monitor. Sampling happens on the falling edge, away from the
   // active edge. Every strobe must match the oldest queued expectation.
   always @(negedge clk100) begin
      if (data_out) begin
         exp_t e;
         strobes++;
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("[TB] FAIL unexpected_strobe: queued=%0d required>=1", sb.size());
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_output("strobe_i_val", i_val, e.i);
            check_output("strobe_q_val", q_val, e.q);
         end
      end
   end

   initial begin
      int tone_i[4];
      int tone_q[4];
      int samp[$];
      int s0;

      tone_i = '{100, 0, -100, 0};
      tone_q = '{0, 100, 0, -100};

      rst_n        = 1'b0;
      trigger      = 1'b0;
      adc_valid    = 1'b0;
      adc_data     = '0;
      delay_cycles = '0;
      integ_len    = '0;

      // Check the reset state.
      #12;
      check_output("reset_i_val", i_val, 0);
      check_output("reset_q_val", q_val, 0);
      check_output("reset_data_out", data_out, 0);
      check_output("reset_busy", busy, 0);
      @(posedge clk100);
      #1;
      rst_n = 1'b1;
      apply_stimulus(0, 0);

      // In-phase tone, no delay, 8 samples.
      $display("[TB] in-phase tone");
      samp = {};
      for (int k = 0; k < 8; k++) samp.push_back(tone_i[k % 4]);
      sb.push_back(demod(samp));
      start_measure(0, 8);
      check_output("inphase_busy", busy, 1);
      for (int k = 0; k < 8; k++) begin
         check_output("inphase_no_early_strobe", data_out, 0);
         apply_stimulus(1, tone_i[k % 4]);
      end
      check_output("inphase_strobe", data_out, 1);
      check_output("inphase_output_busy", busy, 1);
      apply_stimulus(0, 0);
      check_output("inphase_strobe_one_cycle", data_out, 0);
      check_output("inphase_idle_busy", busy, 0);

      // Quadrature tone. A trigger raised during OUTPUT must be ignored.
      $display("[TB] quadrature tone");
      samp = {};
      for (int k = 0; k < 8; k++) samp.push_back(tone_q[k % 4]);
      sb.push_back(demod(samp));
      start_measure(0, 8);
      for (int k = 0; k < 8; k++) apply_stimulus(1, tone_q[k % 4]);
      check_output("quad_strobe", data_out, 1);
      trigger   = 1'b1;
      integ_len = 16'd4;
      apply_stimulus(0, 0);
      trigger = 1'b0;
      check_output("quad_output_trigger_ignored", busy, 0);

      // DC input with valid gaps. The 4th valid sample is accepted at step 7.
      $display("[TB] dc rejection with gaps");
      samp = '{100, 100, 100, 100};
      sb.push_back(demod(samp));
      start_measure(0, 4);
      for (int k = 0; k < 7; k++) begin
         if (k == 6) check_output("dc_no_early_strobe", data_out, 0);
         apply_stimulus((k % 2) == 0, 100);
      end
      check_output("dc_strobe", data_out, 1);
      apply_stimulus(0, 0);

      // Delay of 3. The first three samples arrive during DELAY and are
      // dropped. Integration starts with the fourth sample of the stream.
      $display("[TB] delayed start");
      samp = {};
      for (int k = 3; k < 7; k++) samp.push_back(tone_i[k % 4]);
      sb.push_back(demod(samp));
      start_measure(3, 4);
      check_output("delay_busy", busy, 1);
      for (int k = 0; k < 7; k++) begin
         if (k == 6) check_output("delay_no_early_strobe", data_out, 0);
         apply_stimulus(1, tone_i[k % 4]);
      end
      check_output("delay_strobe", data_out, 1);
      apply_stimulus(0, 0);

      // Triggers that arrive mid-integration and on the last sample are ignored.
      $display("[TB] retrigger while busy");
      samp = {};
      for (int k = 0; k < 8; k++) samp.push_back(tone_i[k % 4]);
      sb.push_back(demod(samp));
      s0 = strobes;
      start_measure(0, 8);
      for (int k = 0; k < 8; k++) begin
         trigger = (k == 2) || (k == 7);
         apply_stimulus(1, tone_i[k % 4]);
      end
      trigger = 1'b0;
      for (int k = 0; k < 4; k++) apply_stimulus(1, 100);
      check_output("retrigger_strobe_count", strobes - s0, 1);
      check_output("retrigger_busy", busy, 0);

      // A trigger with a length of zero is ignored.
      $display("[TB] zero length trigger");
      s0 = strobes;
      start_measure(5, 0);
      check_output("len0_busy", busy, 0);
      for (int k = 0; k < 3; k++) apply_stimulus(1, 100);
      check_output("len0_busy_later", busy, 0);
      check_output("len0_no_strobe", strobes - s0, 0);

      // Most negative ADC code, single sample.
      $display("[TB] most negative sample");
      samp = '{-8192};
      sb.push_back(demod(samp));
      start_measure(0, 1);
      apply_stimulus(1, -8192);
      check_output("neg_strobe", data_out, 1);
      apply_stimulus(0, 0);

      // Asynchronous reset in the middle of INTEGRATE.
      $display("[TB] reset mid-integration");
      s0 = strobes;
      start_measure(0, 8);
      for (int k = 0; k < 3; k++) apply_stimulus(1, 100);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midreset_i_val", i_val, 0);
      check_output("midreset_q_val", q_val, 0);
      check_output("midreset_data_out", data_out, 0);
      check_output("midreset_busy", busy, 0);
      @(posedge clk100);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) apply_stimulus(1, 100);
      check_output("midreset_no_strobe", strobes - s0, 0);
      check_output("midreset_busy_after", busy, 0);

      check_output("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
